// File: rtl/alu_pkg.sv
// alu_pkg: shared constants, FSM encoding and step-count helper for the
// serial_adder datapath unit.
package alu_pkg;

  localparam int SA_WIDTH_DEFAULT = 32;
  localparam int SA_CHUNK_DEFAULT = 4;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } saState_t;

  function automatic int saSteps(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple of full-adder cells.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] in_1,
  input  logic [CHUNK-1:0] in_2,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out
);

  always_comb begin
    logic w_ripple;
    w_ripple = c_in;
    sum      = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = in_1[i] ^ in_2[i] ^ w_ripple;
      w_ripple = (in_1[i] & in_2[i]) | (w_ripple & (in_1[i] ^ in_2[i]));
    end
    c_out = w_ripple;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder/subtractor working CHUNK bits per clock.
// Define SERIAL_ADDER_SUB_EN to honour the sub input; otherwise sub is ignored.
module serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT,
  parameter int CHUNK = SA_CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = saSteps(WIDTH, CHUNK);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_widthCheck
    $fatal(1, "serial_adder: WIDTH must be a multiple of CHUNK");
  end

  saState_t         r_state;
  saState_t         w_stateNext;
  logic             w_accept;
  logic             w_lastStep;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_aMsb;
  logic             r_bMsb;
  logic             r_cOut;
  logic             r_ovf;
  logic [WIDTH-1:0] w_bIn;
  logic             w_cIn;
  logic [CHUNK-1:0] w_chunkSum;
  logic             w_chunkCout;
  logic [WIDTH-1:0] w_sumNext;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1; c_in is ignored for sub.
  assign w_bIn = sub ? ~b : b;
  assign w_cIn = sub ? 1'b1 : c_in;
`else
  logic w_unusedSub;
  assign w_unusedSub = sub;
  assign w_bIn       = b;
  assign w_cIn       = c_in;
`endif

  chunk_adder #(.CHUNK(CHUNK)) u_chunkAdder (
    .in_1  (r_a[CHUNK-1:0]),
    .in_2  (r_b[CHUNK-1:0]),
    .c_in  (r_carry),
    .sum   (w_chunkSum),
    .c_out (w_chunkCout)
  );

  // Result chunks enter at the top so the LSB chunk ends up at the bottom.
  if (CHUNK == WIDTH) begin : g_sumWhole
    assign w_sumNext = w_chunkSum;
  end else begin : g_sumShift
    assign w_sumNext = {w_chunkSum, r_sum[WIDTH-1:CHUNK]};
  end

  assign w_lastStep = (r_count == CW'(N - 1));

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      SA_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_stateNext = SA_RUN;
        end
      end
      SA_RUN: begin
        busy = 1'b1;
        if (w_lastStep) w_stateNext = SA_DONE;
      end
      SA_DONE: begin
        done = 1'b1;
        if (start) begin
          w_accept    = 1'b1;
          w_stateNext = SA_RUN;
        end else begin
          w_stateNext = SA_IDLE;
        end
      end
      default: w_stateNext = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SA_IDLE;
    else        r_state <= w_stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_aMsb  <= 1'b0;
      r_bMsb  <= 1'b0;
      r_cOut  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_a     <= a;
      r_b     <= w_bIn;
      r_carry <= w_cIn;
      r_aMsb  <= a[WIDTH-1];
      r_bMsb  <= w_bIn[WIDTH-1];
    end else if (r_state == SA_RUN) begin
      r_count <= r_count + CW'(1);
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_chunkCout;
      r_sum   <= w_sumNext;
      if (w_lastStep) begin
        r_cOut <= w_chunkCout;
        r_ovf  <= (r_aMsb == r_bMsb) && (w_chunkSum[CHUNK-1] != r_aMsb);
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cOut;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8, CHUNK=2.
// Sub expectations follow SERIAL_ADDER_SUB_EN as seen by this compile.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       c_out;
  logic       ovf;

  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycleCount  = 0;
  exp_t scoreboard[$];

  serial_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic exp_t modelOp(input logic [7:0] ma, input logic [7:0] mb, input logic mcin, input logic msub);
    logic [8:0] full;
    logic [7:0] bEff;
    logic       cEff;
    exp_t       r;
    bEff = mb;
    cEff = mcin;
`ifdef SERIAL_ADDER_SUB_EN
    if (msub) begin
      bEff = ~mb;
      cEff = 1'b1;
    end
`endif
    full   = {1'b0, ma} + {1'b0, bEff} + {8'd0, cEff};
    r.sum  = full[7:0];
    r.cout = full[8];
    r.ovf  = (ma[7] == bEff[7]) && (full[7] != ma[7]);
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = scoreboard.pop_front();
        checkOutput("sum", {24'd0, sum}, {24'd0, e.sum});
        checkOutput("c_out", {31'd0, c_out}, {31'd0, e.cout});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
  end

  // Issue one op from just after a negedge; returns at the negedge showing done.
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic icin, input logic isub,
                               input exp_t e, input int glitchAt, output int lat, output int busyCnt);
    a     = ia;
    b     = ib;
    c_in  = icin;
    sub   = isub;
    start = 1'b1;
    scoreboard.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    lat     = 0;
    busyCnt = 0;
    while (!done && lat < 20) begin
      if (busy) busyCnt++;
      if (lat == glitchAt) begin
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h33;
        c_in  = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    if (lat >= 20) checkOutput("done timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int   lat;
    int   busyCnt;
    int   firstDone;
    exp_t eSub1;
    exp_t eSub2;

`ifdef SERIAL_ADDER_SUB_EN
    eSub1 = '{8'hFE, 1'b0, 1'b0};
    eSub2 = '{8'h7F, 1'b1, 1'b1};
`else
    eSub1 = '{8'h0C, 1'b0, 1'b0};
    eSub2 = '{8'h81, 1'b0, 1'b0};
`endif

    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset sum", {24'd0, sum}, 32'd0);
    checkOutput("reset c_out", {31'd0, c_out}, 32'd0);
    checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b0}, -1, lat, busyCnt);
    checkOutput("latency", lat, 32'd4);
    checkOutput("busy cycles", busyCnt, 32'd4);
    checkOutput("busy in done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("done one cycle", {31'd0, done}, 32'd0);
    checkOutput("sum held", {24'd0, sum}, 32'h10);

    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b0}, -1, lat, busyCnt);
    @(negedge clk);
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}, -1, lat, busyCnt);
    @(negedge clk);
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1}, -1, lat, busyCnt);
    @(negedge clk);
    applyStimulus(8'h05, 8'h07, 1'b0, 1'b1, eSub1, -1, lat, busyCnt);
    @(negedge clk);
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b1, eSub2, -1, lat, busyCnt);
    @(negedge clk);

    // Start pulse mid-RUN must be ignored; no extra done may follow.
    applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b0}, 1, lat, busyCnt);
    checkOutput("glitch latency", lat, 32'd4);
    repeat (3) @(negedge clk);
    checkOutput("glitch idle busy", {31'd0, busy}, 32'd0);

    // Back-to-back: start held during the done cycle.
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1}, -1, lat, busyCnt);
    firstDone = cycleCount;
    applyStimulus(8'h12, 8'h34, 1'b1, 1'b0, '{8'h47, 1'b0, 1'b0}, -1, lat, busyCnt);
    checkOutput("back-to-back gap", cycleCount - firstDone, 32'd5);
    @(negedge clk);

    // Reset during step 2 aborts the op with no done pulse.
    a     = 8'hA5;
    b     = 8'h3C;
    c_in  = 1'b0;
    sub   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort sum", {24'd0, sum}, 32'd0);
    checkOutput("abort c_out", {31'd0, c_out}, 32'd0);
    checkOutput("abort ovf", {31'd0, ovf}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("post-abort done", {31'd0, done}, 32'd0);
    end
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1}, -1, lat, busyCnt);
    @(negedge clk);

    for (int i = 0; i < 10000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      logic       rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      applyStimulus(ra, rb, rc, rs, modelOp(ra, rb, rc, rs), -1, lat, busyCnt);
      @(negedge clk);
    end

    checkOutput("scoreboard empty", scoreboard.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #950000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
